// File: rtl/md_pkg.sv
// md_pkg: shared md_op encodings, FSM states and default latencies for the multiply/divide unit
package md_pkg;
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_t;
   typedef enum logic {S_IDLE, S_RUN} md_state_t;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational HI/LO result generator for mult/multu/div/divu
// Ports: md_op (operation), a/b (rs/rt operands), hi/lo (result halves),
//        div_by_zero (divide op with b==0; result must not be committed)
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);
   logic signed [63:0] sa, sb, prod_s;
   logic [63:0] prod_u;
   logic        is_div, sgn;
   logic [31:0] num, den, q_u, r_u, q, r;
   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
   always_comb begin
      sa          = {{32{a[31]}}, a};
      sb          = {{32{b[31]}}, b};
      prod_s      = sa * sb;
      prod_u      = {32'b0, a} * {32'b0, b};
      is_div      = md_op == MD_DIV || md_op == MD_DIVU;
      sgn         = md_op == MD_DIV;
      div_by_zero = is_div && b == '0;
      num         = sgn && a[31] ? -a : a;
      den         = b == '0 ? 32'd1 : sgn && b[31] ? -b : b;
      q_u         = num / den;
      r_u         = num % den;
      q           = sgn && (a[31] ^ b[31]) ? -q_u : q_u;
      r           = sgn && a[31] ? -r_u : r_u;
      {hi, lo}    = md_op == MD_MULT  ? prod_s :
                    md_op == MD_MULTU ? prod_u :
                    is_div            ? {r, q} : 64'b0;
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit owning HI/LO with fixed-latency mult/div
// Ports: clk, reset (sync active-high), start (E-stage md arithmetic op), md_op,
//        A/B (forwarded rs/rt), busy (op in flight, to stall unit), HI/LO (architectural regs)
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int CNT_W = 16;
   md_state_t   state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0] hi_tmp, lo_tmp, hi_tmp_n, lo_tmp_n, hi_n, lo_n, calc_hi, calc_lo;
   logic        dz, dz_n, calc_dz, is_arith, is_div;
   md_calc u_calc (
      .md_op      (md_op),
      .a          (A),
      .b          (B),
      .hi         (calc_hi),
      .lo         (calc_lo),
      .div_by_zero(calc_dz)
   );
   assign busy = state == S_RUN;
   always_comb begin
      is_arith = md_op == MD_MULT || md_op == MD_MULTU || md_op == MD_DIV || md_op == MD_DIVU;
      is_div   = md_op == MD_DIV || md_op == MD_DIVU;
      state_n  = state;
      cnt_n    = cnt;
      hi_tmp_n = hi_tmp;
      lo_tmp_n = lo_tmp;
      dz_n     = dz;
      hi_n     = HI;
      lo_n     = LO;
      if (state == S_IDLE) begin
         if (start && is_arith) begin
            state_n  = S_RUN;
            cnt_n    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            hi_tmp_n = calc_hi;
            lo_tmp_n = calc_lo;
            dz_n     = calc_dz;
         end else begin
            hi_n = md_op == MD_MTHI ? A : HI;
            lo_n = md_op == MD_MTLO ? A : LO;
         end
      end else begin
         cnt_n = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            state_n = S_IDLE;
            hi_n    = dz ? HI : hi_tmp;
            lo_n    = dz ? LO : lo_tmp;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         dz     <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         hi_tmp <= hi_tmp_n;
         lo_tmp <= lo_tmp_n;
         dz     <= dz_n;
         HI     <= hi_n;
         LO     <= lo_n;
      end
   end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It owns the HI/LO registers and runs mult/multu/div/divu as fixed-latency multi-cycle operations. During an operation it drives `busy`, which the stall unit uses to hold md-class instructions (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) in D. It also serves mthi/mtlo writes and provides HI/LO for mfhi/mflo forwarding.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is mult/multu/div/divu; valid for one cycle
- md_op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE (encodings in package)
- A  input  32  rs operand, after forwarding
- B  input  32  rt operand, after forwarding
- busy  output  1  operation in progress; feeds the stall unit's alubusy input
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- State: IDLE, RUN. A down-counter `cnt` tracks remaining cycles.
- IDLE, `start`=1 with MULT/MULTU/DIV/DIVU:
  - Latch the result into internal hi_tmp/lo_tmp.
  - Load `cnt` with the op's cycle count.
  - Go to RUN.
- RUN:
  - Decrement `cnt` every cycle.
  - On the edge where `cnt`==1: commit hi_tmp/lo_tmp to HI/LO, then go to IDLE.
- `busy` = (state==RUN), registered.
- MTHI/MTLO in IDLE: write A to HI or LO at the same edge. No busy cycle.
- Arithmetic:
  - MULT: signed 32×32→64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: as MULT, but unsigned.
  - DIV: signed, quotient truncates toward zero. LO = quotient; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B==0): the op still runs the full DIV_CYCLES with busy asserted; HI/LO are left unchanged at commit.
- Inputs ignored in RUN: `start` and MTHI/MTLO are dropped. The stall unit guarantees they do not arrive; the block still must not corrupt state.
- `start`=1 with md_op=NONE/MTHI/MTLO: `start` is ignored; MTHI/MTLO follows the md_op rule.
- Reset (any state, including mid-RUN):
  - HI=0, LO=0, busy=0, cnt=0, state=IDLE.
  - Any pending result is discarded.

## Timing
- `start` sampled at edge E0 → busy=1 from the cycle after E0 for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
- HI/LO take the new value at the edge where busy falls, and are visible in the same cycle busy reads 0.
- Back-to-back: a new `start` may be accepted in the first cycle busy=0.
- mthi/mtlo: HI/LO updated one edge after the instruction is in E. mfhi in E the following cycle reads the new value.
- All outputs come straight from registers; no combinational path from inputs to outputs.
- Reset values: busy=0, HI=0x00000000, LO=0x00000000.

## Structure
- Shared package `md_pkg`:
  - md_op encodings: NONE=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
  - Default cycle constants: 5 and 10.
- Sub-module `md_calc`: purely combinational. Takes md_op, A and B and produces {hi_tmp, lo_tmp} plus a div_by_zero flag. The top level holds the FSM, counter and HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- HI=0x11, LO=0x22 preset via MTHI/MTLO, then DIV with B=0 → busy high 10 cycles; HI=0x11, LO=0x22 unchanged.
- Reset asserted in the 3rd busy cycle of a MULT → next cycle busy=0, HI=LO=0; no late commit follows.
- MTHI A=0xDEADBEEF while busy → ignored: HI after commit equals the mult result. MTLO 0x1234 in IDLE → LO=0x1234 next cycle, busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Second MULT started in the first non-busy cycle → accepted; busy rises one cycle later.
